// File: rtl/numchar_seq_if.sv
// Bundle for the NUM/CHAR/HLT sequencer: dispatch/writeback to main control plus the
// NUM and CHAR conversion-unit handshakes. The sequencer itself uses the slave modport.
interface numchar_seq_if;
   logic        start;
   logic [5:0]  field;
   logic [30:0] a_in;
   logic [30:0] x_in;
   logic        resume;
   logic        busy;
   logic        done;
   logic        err;
   logic        illegal;
   logic        halt;
   logic [30:0] a_out;
   logic        a_we;
   logic [30:0] x_out;
   logic        x_we;
   logic        ovf_set;
   logic        num_start;
   logic [59:0] num_in;
   logic [29:0] num_out;
   logic        num_stop;
   logic        char_start;
   logic [29:0] char_in;
   logic [59:0] char_out;
   logic        char_stop;

   modport master (
      output start, field, a_in, x_in, resume,
      output num_out, num_stop, char_out, char_stop,
      input  busy, done, err, illegal, halt,
      input  a_out, a_we, x_out, x_we, ovf_set,
      input  num_start, num_in, char_start, char_in
   );

   modport slave (
      input  start, field, a_in, x_in, resume,
      input  num_out, num_stop, char_out, char_stop,
      output busy, done, err, illegal, halt,
      output a_out, a_we, x_out, x_we, ovf_set,
      output num_start, num_in, char_start, char_in
   );
endinterface

// File: rtl/numchar_seq.sv
// MIX C=5 sequencer (NUM/CHAR/HLT): launches the shared conversion unit, watches for stop
// with a timeout, writes rA/rX back. Define NUMCHAR_OVF_EN to add NUM overflow detection.
module numchar_seq #(
   parameter int unsigned TIMEOUT = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   numchar_seq_if.slave bus
);

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, WRITE, DONE} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        op_char_q;
   logic        err_q;
   logic        ill_q;
   logic        halt_q;
   logic [30:0] a_q;
   logic [30:0] x_q;
   logic [7:0]  cnt_q;
   logic [59:0] opnd;
   logic        accept;
   logic        sel_stop;
   logic        go_write;
   logic        ovf_hit;
   logic        timed_out;

   assign accept    = (state_q == IDLE) && bus.start && !halt_q;
   assign sel_stop  = op_char_q ? bus.char_stop : bus.num_stop;
   assign opnd      = {a_q[29:0], x_q[29:0]};
   assign timed_out = (state_q == WAIT) && !go_write && (cnt_q == TO_LAST);

`ifdef NUMCHAR_OVF_EN
   typedef enum logic [1:0] {CMP_EQ, CMP_GT, CMP_LT} cmp_t;

   cmp_t        cmp_q;
   logic [3:0]  idx_q;
   logic        stop_seen_q;
   logic        cmp_done;
   logic [59:0] opnd_sh;
   logic [5:0]  byte_v;
   logic [3:0]  dig;
   logic [3:0]  ref_d;

   // Digits of 1073741824 (2^30), most significant first.
   always_comb begin
      opnd_sh = opnd << (6 * idx_q);
      byte_v  = opnd_sh[59:54];
      dig     = 4'(byte_v % 6'd10);
      case (idx_q)
         4'd0:    ref_d = 4'd1;
         4'd1:    ref_d = 4'd0;
         4'd2:    ref_d = 4'd7;
         4'd3:    ref_d = 4'd3;
         4'd4:    ref_d = 4'd7;
         4'd5:    ref_d = 4'd4;
         4'd6:    ref_d = 4'd1;
         4'd7:    ref_d = 4'd8;
         4'd8:    ref_d = 4'd2;
         4'd9:    ref_d = 4'd4;
         default: ref_d = 4'd0;
      endcase
   end

   assign cmp_done = (idx_q == 4'd10);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmp_q       <= CMP_EQ;
         idx_q       <= '0;
         stop_seen_q <= 1'b0;
      end else if (accept) begin
         cmp_q       <= CMP_EQ;
         idx_q       <= '0;
         stop_seen_q <= 1'b0;
      end else begin
         if ((state_q == LAUNCH || state_q == WAIT) && !cmp_done) begin
            idx_q <= idx_q + 4'd1;
            if (cmp_q == CMP_EQ) begin
               if (dig > ref_d)      cmp_q <= CMP_GT;
               else if (dig < ref_d) cmp_q <= CMP_LT;
            end
         end
         if (state_q == WAIT && sel_stop) stop_seen_q <= 1'b1;
      end
   end

   // A stop that arrives before the compare finishes is remembered, not lost.
   assign go_write = (sel_stop || stop_seen_q) && (op_char_q || cmp_done);
   assign ovf_hit  = (cmp_q != CMP_LT);
`else
   assign go_write = sel_stop;
   assign ovf_hit  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (bus.field == 6'd0 || bus.field == 6'd1) state_d = LAUNCH;
               else                                        state_d = DONE;
            end
         end
         LAUNCH: state_d = WAIT;
         WAIT: begin
            if (go_write)       state_d = WRITE;
            else if (timed_out) state_d = DONE;
         end
         WRITE:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_char_q <= 1'b0;
         err_q     <= 1'b0;
         ill_q     <= 1'b0;
         halt_q    <= 1'b0;
         a_q       <= '0;
         x_q       <= '0;
         cnt_q     <= '0;
      end else begin
         if (accept) begin
            op_char_q <= bus.field[0];
            err_q     <= 1'b0;
            ill_q     <= (bus.field > 6'd2);
            a_q       <= bus.a_in;
            x_q       <= bus.x_in;
            cnt_q     <= '0;
         end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + 8'd1;
            if (timed_out) err_q <= 1'b1;
         end
         // A same-cycle HLT dispatch overrides resume.
         if (accept && bus.field == 6'd2) halt_q <= 1'b1;
         else if (bus.resume)            halt_q <= 1'b0;
      end
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == DONE);
   assign bus.err        = (state_q == DONE) && err_q;
   assign bus.illegal    = (state_q == DONE) && ill_q;
   assign bus.halt       = halt_q;
   assign bus.num_start  = (state_q == LAUNCH) && !op_char_q;
   assign bus.char_start = (state_q == LAUNCH) && op_char_q;
   assign bus.num_in     = opnd;
   assign bus.char_in    = a_q[29:0];
   assign bus.a_we       = (state_q == WRITE);
   assign bus.x_we       = (state_q == WRITE) && op_char_q;
   assign bus.ovf_set    = (state_q == WRITE) && !op_char_q && ovf_hit;

   always_comb begin
      bus.a_out = '0;
      bus.x_out = '0;
      if (state_q == WRITE) begin
         if (op_char_q) begin
            bus.a_out = {a_q[30], bus.char_out[59:30]};
            bus.x_out = {x_q[30], bus.char_out[29:0]};
         end else begin
            bus.a_out = {a_q[30], bus.num_out};
         end
      end
   end

endmodule

// File: tb/tb_numchar_seq.sv
// Directed bench for numchar_seq; behavioural NUM/CHAR units answer the launch pulses.
module tb_numchar_seq;
   localparam int unsigned TO = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   numchar_seq_if bif ();
   numchar_seq #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

   int tests_run = 0;
   int tests_failed = 0;

   int n_nstart, n_cstart, n_done, n_err, n_ill, n_awe, n_xwe, n_both, n_ovf;
   int done_cyc, busy_c1, busy_after;
   logic [30:0] cap_a, cap_x;
   logic [59:0] cap_nin;
   logic [29:0] cap_cin;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [29:0] num_model(input logic [59:0] v);
      longint acc;
      logic [5:0] b;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         b = v[59 - 6*i -: 6];
         acc = acc * 10 + longint'(int'(b) % 10);
      end
      return acc[29:0];
   endfunction

   function automatic logic [59:0] char_model(input logic [29:0] m);
      logic [59:0] r;
      int unsigned v;
      v = 32'(m);
      r = '0;
      for (int i = 0; i < 10; i++) begin
         r[6*i +: 6] = 6'(30 + v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic run_op(input logic [5:0] f, input logic [30:0] a, input logic [30:0] x,
                         input int lat, input bit noise, input int limit);
      int stop_at;
      int post;
      bit is_char_u;
      stop_at = -1; post = -1; is_char_u = 1'b0;
      n_nstart = 0; n_cstart = 0; n_done = 0; n_err = 0; n_ill = 0;
      n_awe = 0; n_xwe = 0; n_both = 0; n_ovf = 0;
      done_cyc = -1; busy_c1 = -1; busy_after = -1;
      cap_a = '0; cap_x = '0; cap_nin = '0; cap_cin = '0;
      @(negedge clk);
      bif.start = 1'b1; bif.field = f; bif.a_in = a; bif.x_in = x;
      @(negedge clk);
      bif.start = 1'b0;
      for (int c = 1; c <= limit; c++) begin
         if (c > 1) @(negedge clk);
         if (bif.num_start) begin
            n_nstart++; cap_nin = bif.num_in; stop_at = c + lat; is_char_u = 1'b0;
            bif.num_out = num_model(bif.num_in);
         end
         if (bif.char_start) begin
            n_cstart++; cap_cin = bif.char_in; stop_at = c + lat; is_char_u = 1'b1;
            bif.char_out = char_model(bif.char_in);
         end
         if (c == 1) busy_c1 = int'(bif.busy);
         if (bif.a_we) begin n_awe++; cap_a = bif.a_out; end
         if (bif.x_we) begin n_xwe++; cap_x = bif.x_out; end
         if (bif.a_we && bif.x_we) n_both++;
         if (bif.ovf_set) n_ovf++;
         if (bif.err) n_err++;
         if (bif.illegal) n_ill++;
         if (bif.done) begin n_done++; done_cyc = c; post = c + 2; end
         if (c == post) begin busy_after = int'(bif.busy); break; end
         bif.num_stop  = !is_char_u && (c == stop_at);
         bif.char_stop = (is_char_u && (c == stop_at)) || (noise && !is_char_u && (c % 5 == 3));
      end
      bif.num_stop = 1'b0;
      bif.char_stop = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ctl"}, 64'({bif.busy, bif.done, bif.err, bif.illegal, bif.halt, bif.a_we,
                                bif.x_we, bif.ovf_set, bif.num_start, bif.char_start}), 64'd0);
      check({tag, "_data"}, 64'({bif.a_out, bif.x_out}), 64'd0);
      check({tag, "_opnd"}, {bif.num_in, 4'd0}, 64'd0);
      check({tag, "_cin"}, 64'(bif.char_in), 64'd0);
   endtask

   logic [30:0] num_a, num_x;
   int exp_num_done;
   int cnt_d, cnt_w;

   initial begin
      bif.start = 1'b0; bif.field = '0; bif.a_in = '0; bif.x_in = '0; bif.resume = 1'b0;
      bif.num_out = '0; bif.num_stop = 1'b0; bif.char_out = '0; bif.char_stop = 1'b0;
      num_a = {1'b1, 6'd0, 6'd0, 6'd31, 6'd32, 6'd39};
      num_x = {1'b0, 6'd37, 6'd57, 6'd47, 6'd30, 6'd30};
`ifdef NUMCHAR_OVF_EN
      exp_num_done = 13;
`else
      exp_num_done = 6;
`endif
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;

      // NUM: -{00,00,31,32,39} / +{37,57,47,30,30} -> -12977700
      run_op(6'd0, num_a, num_x, 3, 1'b0, 60);
      check("num_start_cnt", 64'(n_nstart), 64'd1);
      check("num_cstart_cnt", 64'(n_cstart), 64'd0);
      check("num_in", 64'(cap_nin),
            64'({6'd0, 6'd0, 6'd31, 6'd32, 6'd39, 6'd37, 6'd57, 6'd47, 6'd30, 6'd30}));
      check("num_awe", 64'(n_awe), 64'd1);
      check("num_a_out", 64'(cap_a), 64'({1'b1, 30'd12977700}));
      check("num_xwe", 64'(n_xwe), 64'd0);
      check("num_done", 64'(n_done), 64'd1);
      check("num_latency", 64'(done_cyc), 64'(exp_num_done));
      check("num_ovf", 64'(n_ovf), 64'd0);
      check("num_busy_c1", 64'(busy_c1), 64'd1);
      check("num_busy_after", 64'(busy_after), 64'd0);

      // CHAR: +12977699 / -0
      run_op(6'd1, {1'b0, 30'd12977699}, {1'b1, 30'd0}, 2, 1'b0, 60);
      check("char_start_cnt", 64'(n_cstart), 64'd1);
      check("char_nstart_cnt", 64'(n_nstart), 64'd0);
      check("char_in", 64'(cap_cin), 64'd12977699);
      check("char_both_we", 64'(n_both), 64'd1);
      check("char_a_out", 64'(cap_a), 64'({1'b0, 6'd30, 6'd30, 6'd31, 6'd32, 6'd39}));
      check("char_x_out", 64'(cap_x), 64'({1'b1, 6'd37, 6'd37, 6'd36, 6'd39, 6'd39}));
      check("char_done", 64'(n_done), 64'd1);
      check("char_latency", 64'(done_cyc), 64'd5);
      check("char_ovf", 64'(n_ovf), 64'd0);

      // Timeout: NUM never stops, CHAR stop noise during WAIT
      run_op(6'd0, num_a, num_x, 1000, 1'b1, 60);
      check("to_done", 64'(n_done), 64'd1);
      check("to_err", 64'(n_err), 64'd1);
      check("to_cycles", 64'(done_cyc - 2), 64'(TO));
      check("to_awe", 64'(n_awe), 64'd0);
      check("to_xwe", 64'(n_xwe), 64'd0);
      check("to_ill", 64'(n_ill), 64'd0);

      // HLT
      run_op(6'd2, '0, '0, 1, 1'b0, 20);
      check("hlt_done", 64'(n_done), 64'd1);
      check("hlt_latency", 64'(done_cyc), 64'd1);
      check("hlt_nstart", 64'(n_nstart), 64'd0);
      check("hlt_halt", 64'(bif.halt), 64'd1);
      run_op(6'd0, num_a, num_x, 3, 1'b0, 20);
      check("halted_done", 64'(n_done), 64'd0);
      check("halted_nstart", 64'(n_nstart), 64'd0);
      check("halted_busy", 64'(busy_c1), 64'd0);
      @(negedge clk); bif.resume = 1'b1;
      @(negedge clk); bif.resume = 1'b0;
      check("resume_halt", 64'(bif.halt), 64'd0);
      // HLT dispatch and resume together: set wins
      @(negedge clk); bif.start = 1'b1; bif.field = 6'd2; bif.resume = 1'b1;
      @(negedge clk); bif.start = 1'b0; bif.resume = 1'b0;
      check("setwins_halt", 64'(bif.halt), 64'd1);
      check("setwins_done", 64'(bif.done), 64'd1);
      @(negedge clk); bif.resume = 1'b1;
      @(negedge clk); bif.resume = 1'b0;
      check("resume2_halt", 64'(bif.halt), 64'd0);

      // Illegal F=7
      run_op(6'd7, num_a, num_x, 1, 1'b0, 20);
      check("ill_done", 64'(n_done), 64'd1);
      check("ill_flag", 64'(n_ill), 64'd1);
      check("ill_err", 64'(n_err), 64'd0);
      check("ill_awe", 64'(n_awe), 64'd0);
      check("ill_latency", 64'(done_cyc), 64'd1);

      // Reset mid-WAIT, late stop ignored
      @(negedge clk); bif.start = 1'b1; bif.field = 6'd0; bif.a_in = num_a; bif.x_in = num_x;
      @(negedge clk); bif.start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_outputs_zero("midrst");
      rst_n = 1'b1;
      bif.num_out = 30'd12345; bif.num_stop = 1'b1;
      @(negedge clk); bif.num_stop = 1'b0;
      cnt_d = 0; cnt_w = 0;
      for (int i = 0; i < 8; i++) begin
         if (bif.done) cnt_d++;
         if (bif.a_we || bif.x_we || bif.busy) cnt_w++;
         @(negedge clk);
      end
      check("midrst_done", 64'(cnt_d), 64'd0);
      check("midrst_activity", 64'(cnt_w), 64'd0);
      run_op(6'd0, num_a, num_x, 3, 1'b0, 60);
      check("post_rst_a_out", 64'(cap_a), 64'({1'b1, 30'd12977700}));
      check("post_rst_done", 64'(n_done), 64'd1);

`ifdef NUMCHAR_OVF_EN
      run_op(6'd0, {1'b0, {5{6'd39}}}, {1'b0, {5{6'd39}}}, 3, 1'b0, 60);
      check("ovf9_a_out", 64'(cap_a), 64'({1'b0, 30'd336323583}));
      check("ovf9_set", 64'(n_ovf), 64'd1);
      check("ovf9_latency", 64'(done_cyc), 64'd13);
      run_op(6'd0, {1'b0, 6'd31, 6'd30, 6'd37, 6'd33, 6'd37},
             {1'b0, 6'd34, 6'd31, 6'd38, 6'd32, 6'd34}, 3, 1'b0, 60);
      check("ovf_eq_set", 64'(n_ovf), 64'd1);
      check("ovf_eq_a_out", 64'(cap_a), 64'({1'b0, 30'd0}));
      run_op(6'd0, {1'b0, 6'd31, 6'd30, 6'd37, 6'd33, 6'd37},
             {1'b0, 6'd34, 6'd31, 6'd38, 6'd32, 6'd33}, 3, 1'b0, 60);
      check("ovf_lt_set", 64'(n_ovf), 64'd0);
      check("ovf_lt_a_out", 64'(cap_a), 64'({1'b0, 30'h3FFF_FFFF}));
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
